// File: rtl/codec_i2c_arbiter.sv
// Round-robin arbiter sharing one WM8731 I2C control engine between NREQ requesters.
// Optional re-issue of failed transfers is enabled by defining CODEC_ARB_RETRY_EN.
module codec_i2c_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 262143,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_word,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [15:0]          eng_word,
    output logic                 eng_start,
    input  logic                 eng_done,
    input  logic [2:0]           eng_ack,
    output logic                 busy
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            eng_done_q;
    logic [15:0]     eng_word_d;
    logic [NREQ-1:0] req_ready_d, req_done_d;
    logic            req_err_d, eng_start_d, busy_d;
    logic [15:0]     words [NREQ];
    logic            grant_found;
    logic [GW-1:0]   grant_idx, cand;
    logic            done_rise_c, tmo_hit_c, success_c;

`ifdef CODEC_ARB_RETRY_EN
    localparam int unsigned RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RCW-1:0]  retry_cnt_q, retry_cnt_d;
    logic            retry_pend_q, retry_pend_d;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_word[16*g +: 16];
    end

    assign done_rise_c = eng_done & ~eng_done_q;
    assign tmo_hit_c   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Round-robin search starting just above the last winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = GW'((32'(last_grant_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        eng_word_d   = eng_word;
        req_ready_d  = '0;
        req_done_d   = '0;
        req_err_d    = 1'b0;
        success_c    = 1'b0;
`ifdef CODEC_ARB_RETRY_EN
        retry_cnt_d  = retry_cnt_q;
        retry_pend_d = retry_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    last_grant_d = grant_idx;
                    eng_word_d   = words[grant_idx];
                    req_ready_d  = NREQ'(1) << grant_idx;
                    state_d      = ISSUE;
`ifdef CODEC_ARB_RETRY_EN
                    retry_cnt_d  = '0;
                    retry_pend_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (done_rise_c || tmo_hit_c) begin
                    state_d   = CHECK;
                    success_c = done_rise_c && (eng_ack == 3'b111);
`ifdef CODEC_ARB_RETRY_EN
                    if (!success_c && (retry_cnt_q < RCW'(MAX_RETRY))) begin
                        retry_pend_d = 1'b1;
                        retry_cnt_d  = retry_cnt_q + RCW'(1);
                    end else begin
                        req_done_d = NREQ'(1) << last_grant_q;
                        req_err_d  = ~success_c;
                    end
`else
                    req_done_d = NREQ'(1) << last_grant_q;
                    req_err_d  = ~success_c;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            CHECK: begin
                gap_cnt_d = '0;
                state_d   = GAP;
            end
            GAP: begin
                if (gap_cnt_q == CW'(GAP_CYCLES - 1)) begin
`ifdef CODEC_ARB_RETRY_EN
                    state_d      = retry_pend_q ? ISSUE : IDLE;
                    retry_pend_d = 1'b0;
`else
                    state_d      = IDLE;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        eng_start_d = (state_d == WAIT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NREQ - 1);
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            eng_done_q   <= 1'b0;
            eng_word     <= 16'h0000;
            req_ready    <= '0;
            req_done     <= '0;
            req_err      <= 1'b0;
            eng_start    <= 1'b0;
            busy         <= 1'b0;
`ifdef CODEC_ARB_RETRY_EN
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            eng_done_q   <= eng_done;
            eng_word     <= eng_word_d;
            req_ready    <= req_ready_d;
            req_done     <= req_done_d;
            req_err      <= req_err_d;
            eng_start    <= eng_start_d;
            busy         <= busy_d;
`ifdef CODEC_ARB_RETRY_EN
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
`endif
        end
    end

endmodule
